// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// hazard_scoreboard: M/W forwarding, load-use/branch stalls and a multi-cycle
// write scoreboard giving RAW/WAW/structural stalls for an NREAD-port pipe.
// Revision: 1.0
// ============================================================================
`ifndef FORWARD_N
`define FORWARD_N 2'b00
`endif
`ifndef FORWARD_W
`define FORWARD_W 2'b01
`endif
`ifndef FORWARD_M
`define FORWARD_M 2'b10
`endif

module hazard_scoreboard #(
  parameter int REG_SIZE = 5,
  parameter int NREAD    = 2,
  parameter int MC_DEPTH = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NREAD*REG_SIZE-1:0]        raddrD,
  input  logic [NREAD*REG_SIZE-1:0]        raddrE,
  input  logic [REG_SIZE-1:0]              writeRegD,
  input  logic                             regWriteD,
  input  logic                             mcOpD,
  input  logic                             controlChangeD,
  input  logic [REG_SIZE-1:0]              writeRegE,
  input  logic [REG_SIZE-1:0]              writeRegM,
  input  logic [REG_SIZE-1:0]              writeRegW,
  input  logic                             regWriteE,
  input  logic                             regWriteM,
  input  logic                             regWriteW,
  input  logic                             mem2regE,
  input  logic                             mem2regM,
  input  logic                             mcDone,
  input  logic [REG_SIZE-1:0]              mcDoneAddr,
  output logic                             stallF,
  output logic                             stallD,
  output logic                             flushD,
  output logic                             flushE,
  output logic [NREAD*2-1:0]               forwardD,
  output logic [NREAD*2-1:0]               forwardE,
  output logic [2**REG_SIZE-1:0]           busy,
  output logic [$clog2(MC_DEPTH+1)-1:0]    mcInflight,
  output logic                             scbErr,
  output logic [31:0]                      stallCnt
);

  localparam int CW = $clog2(MC_DEPTH + 1);
  localparam logic [REG_SIZE-1:0] ZERO_REG = '0;

  logic                  stall;
  logic                  issue;
  logic                  done_ok;
  logic [2**REG_SIZE-1:0] busy_nxt;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_SIZE-1:0] a,
    input logic [REG_SIZE-1:0] wm,
    input logic                rwm,
    input logic [REG_SIZE-1:0] ww,
    input logic                rww
  );
    if (a != ZERO_REG && a == wm && rwm)      return `FORWARD_M;
    else if (a != ZERO_REG && a == ww && rww) return `FORWARD_W;
    else                                      return `FORWARD_N;
  endfunction

  for (genvar i = 0; i < NREAD; i++) begin : g_port
    assign forwardD[i*2 +: 2] = fwd_sel(raddrD[i*REG_SIZE +: REG_SIZE],
                                        writeRegM, regWriteM, writeRegW, regWriteW);
    assign forwardE[i*2 +: 2] = fwd_sel(raddrE[i*REG_SIZE +: REG_SIZE],
                                        writeRegM, regWriteM, writeRegW, regWriteW);
  end

  always_comb begin
    logic                lwstall;
    logic                branchstall;
    logic                rawstall;
    logic                wawstall;
    logic                structstall;
    logic [REG_SIZE-1:0] a;
    lwstall     = 1'b0;
    branchstall = 1'b0;
    rawstall    = 1'b0;
    a           = ZERO_REG;
    for (int i = 0; i < NREAD; i++) begin
      a = raddrD[i*REG_SIZE +: REG_SIZE];
      if (mem2regE && writeRegE != ZERO_REG && a == writeRegE)
        lwstall = 1'b1;
      if (controlChangeD && a != ZERO_REG &&
          ((regWriteE && a == writeRegE) || (mem2regM && a == writeRegM)))
        branchstall = 1'b1;
      if (a != ZERO_REG && busy[a])
        rawstall = 1'b1;
    end
    wawstall    = regWriteD && writeRegD != ZERO_REG && busy[writeRegD];
    structstall = mcOpD && mcInflight == CW'(MC_DEPTH);
    stall       = lwstall | branchstall | rawstall | wawstall | structstall;
  end

  assign stallF  = stall;
  assign stallD  = stall;
  assign flushE  = stall;
  assign flushD  = controlChangeD & ~stall;
  assign issue   = mcOpD & ~stall;
  assign done_ok = mcDone && mcInflight != '0;

  // Clear before set: WAW guarantees a same-cycle issue never targets the retiring register.
  always_comb begin
    busy_nxt = busy;
    if (done_ok && mcDoneAddr != ZERO_REG) busy_nxt[mcDoneAddr] = 1'b0;
    if (issue && writeRegD != ZERO_REG)    busy_nxt[writeRegD]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= '0;
      mcInflight <= '0;
      scbErr     <= 1'b0;
      stallCnt   <= '0;
    end else begin
      busy <= busy_nxt;
      if (issue && !done_ok)
        mcInflight <= mcInflight + CW'(1);
      else if (!issue && done_ok)
        mcInflight <= mcInflight - CW'(1);
      if (mcDone && mcInflight == '0)
        scbErr <= 1'b1;
      if (stall && stallCnt != 32'hFFFF_FFFF)
        stallCnt <= stallCnt + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// tb_hazard_scoreboard: directed plus randomized stimulus, expected outputs
// from a register-set reference model queued and compared by a monitor.
`ifndef FORWARD_N
`define FORWARD_N 2'b00
`endif
`ifndef FORWARD_W
`define FORWARD_W 2'b01
`endif
`ifndef FORWARD_M
`define FORWARD_M 2'b10
`endif

module tb_hazard_scoreboard;
  localparam int RS = 5;
  localparam int NR = 2;
  localparam int MD = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic [RS-1:0] rdD[NR];
  logic [RS-1:0] rdE[NR];
  logic [NR*RS-1:0] raddrD, raddrE;
  logic [RS-1:0] writeRegD, writeRegE, writeRegM, writeRegW, mcDoneAddr;
  logic regWriteD, mcOpD, controlChangeD, regWriteE, regWriteM, regWriteW;
  logic mem2regE, mem2regM, mcDone;
  logic stallF, stallD, flushD, flushE, scbErr;
  logic [NR*2-1:0] forwardD, forwardE;
  logic [31:0] busy;
  logic [1:0] mcInflight;
  logic [31:0] stallCnt;

  assign raddrD = {rdD[1], rdD[0]};
  assign raddrE = {rdE[1], rdE[0]};

  always #5 clk = ~clk;

  hazard_scoreboard #(.REG_SIZE(RS), .NREAD(NR), .MC_DEPTH(MD)) dut (
    .clk(clk), .rst_n(rst_n), .raddrD(raddrD), .raddrE(raddrE),
    .writeRegD(writeRegD), .regWriteD(regWriteD), .mcOpD(mcOpD),
    .controlChangeD(controlChangeD), .writeRegE(writeRegE), .writeRegM(writeRegM),
    .writeRegW(writeRegW), .regWriteE(regWriteE), .regWriteM(regWriteM),
    .regWriteW(regWriteW), .mem2regE(mem2regE), .mem2regM(mem2regM),
    .mcDone(mcDone), .mcDoneAddr(mcDoneAddr), .stallF(stallF), .stallD(stallD),
    .flushD(flushD), .flushE(flushE), .forwardD(forwardD), .forwardE(forwardE),
    .busy(busy), .mcInflight(mcInflight), .scbErr(scbErr), .stallCnt(stallCnt));

  typedef struct packed {
    logic        sF, sD, fD, fE;
    logic [3:0]  fwdD, fwdE;
    logic [31:0] busy;
    logic [1:0]  inf;
    logic        err;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int   passed = 0;
  int   total  = 0;

  // Reference state: pending-register set, in-flight count, error flag, stall tally.
  bit          pend[32];
  int          mcnt;
  bit          merr;
  logic [31:0] msc;
  int          fl[$];

  function automatic logic [1:0] mfwd(input logic [RS-1:0] a);
    if (a != 0 && regWriteM && a == writeRegM) return `FORWARD_M;
    if (a != 0 && regWriteW && a == writeRegW) return `FORWARD_W;
    return `FORWARD_N;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic clr();
    for (int i = 0; i < NR; i++) begin rdD[i] = '0; rdE[i] = '0; end
    writeRegD = '0; writeRegE = '0; writeRegM = '0; writeRegW = '0; mcDoneAddr = '0;
    regWriteD = 0; mcOpD = 0; controlChangeD = 0; regWriteE = 0; regWriteM = 0;
    regWriteW = 0; mem2regE = 0; mem2regM = 0; mcDone = 0;
  endtask

  task automatic step();
    exp_t e;
    bit   hz, iss;
    if (!rst_n) begin
      foreach (pend[r]) pend[r] = 0;
      mcnt = 0; merr = 0; msc = '0; fl.delete();
    end
    hz = 0;
    for (int i = 0; i < NR; i++) begin
      if (mem2regE && writeRegE != 0 && rdD[i] == writeRegE) hz = 1;
      if (controlChangeD && rdD[i] != 0 &&
          ((regWriteE && rdD[i] == writeRegE) || (mem2regM && rdD[i] == writeRegM))) hz = 1;
      if (rdD[i] != 0 && pend[rdD[i]]) hz = 1;
      e.fwdD[i*2 +: 2] = mfwd(rdD[i]);
      e.fwdE[i*2 +: 2] = mfwd(rdE[i]);
    end
    if (regWriteD && writeRegD != 0 && pend[writeRegD]) hz = 1;
    if (mcOpD && mcnt == MD) hz = 1;
    e.sF = hz; e.sD = hz; e.fE = hz; e.fD = controlChangeD && !hz;
    for (int r = 0; r < 32; r++) e.busy[r] = pend[r];
    e.inf = 2'(mcnt); e.err = merr; e.sc = msc;
    q.push_back(e);
    iss = mcOpD && !hz;
    @(posedge clk);
    if (rst_n) begin
      if (mcDone) begin
        if (mcnt > 0) begin
          mcnt--;
          if (mcDoneAddr != 0) pend[mcDoneAddr] = 0;
          for (int k = 0; k < fl.size(); k++)
            if (fl[k] == int'(mcDoneAddr)) begin fl.delete(k); break; end
        end else merr = 1;
      end
      if (iss) begin
        mcnt++;
        if (writeRegD != 0) pend[writeRegD] = 1;
        fl.push_back(int'(writeRegD));
      end
      if (hz && msc != 32'hFFFF_FFFF) msc = msc + 1;
    end
    #1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stallF", 32'(stallF), 32'(e.sF));
        chk("stallD", 32'(stallD), 32'(e.sD));
        chk("flushD", 32'(flushD), 32'(e.fD));
        chk("flushE", 32'(flushE), 32'(e.fE));
        chk("forwardD", 32'(forwardD), 32'(e.fwdD));
        chk("forwardE", 32'(forwardE), 32'(e.fwdE));
        chk("busy", busy, e.busy);
        chk("mcInflight", 32'(mcInflight), 32'(e.inf));
        chk("scbErr", 32'(scbErr), 32'(e.err));
        chk("stallCnt", stallCnt, e.sc);
      end
    end
  end

  initial begin : driver
    rst_n = 0;
    clr();
    @(posedge clk); #1;
    step();                                   // reset state
    rst_n = 1;
    step();
    // load-use
    mem2regE = 1; writeRegE = 3; rdD[1] = 3; step();
    // forward priority, then register 0
    clr(); rdE[0] = 5; writeRegM = 5; writeRegW = 5; regWriteM = 1; regWriteW = 1; step();
    rdE[0] = 0; step();
    // multi-cycle RAW on r7
    clr(); mcOpD = 1; regWriteD = 1; writeRegD = 7; step();
    clr(); rdD[0] = 7; repeat (3) step();
    mcDone = 1; mcDoneAddr = 7; step();
    mcDone = 0; step(); step();
    // WAW / structural
    clr(); mcOpD = 1; regWriteD = 1; writeRegD = 1; step();
    writeRegD = 2; step();
    writeRegD = 3; step();                    // third op: structural stall
    mcOpD = 0; writeRegD = 1; step();         // ALU write to busy r1
    mcOpD = 1; writeRegD = 4; mcDone = 1; mcDoneAddr = 1; step();
    clr(); step();
    mcDone = 1; mcDoneAddr = 2; step();
    mcDoneAddr = 4; step();
    // spurious completion, then reset mid-flight
    mcDone = 1; mcDoneAddr = 9; step();
    clr(); step();
    mcOpD = 1; regWriteD = 1; writeRegD = 6; step();
    clr(); rdD[1] = 6; step();
    rst_n = 0; step();
    rst_n = 1; step();
    // branch
    controlChangeD = 1; step();
    writeRegE = 2; regWriteE = 1; rdD[0] = 2; step();
    clr(); step();
    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NR; i++) begin
        rdD[i] = RS'($urandom_range(0, 7));
        rdE[i] = RS'($urandom_range(0, 7));
      end
      writeRegE = RS'($urandom_range(0, 7)); writeRegM = RS'($urandom_range(0, 7));
      writeRegW = RS'($urandom_range(0, 7)); writeRegD = RS'($urandom_range(0, 7));
      regWriteE = 1'($urandom); regWriteM = 1'($urandom); regWriteW = 1'($urandom);
      mem2regE = ($urandom_range(0, 3) == 0); mem2regM = ($urandom_range(0, 3) == 0);
      controlChangeD = ($urandom_range(0, 4) == 0);
      mcOpD = ($urandom_range(0, 2) == 0);
      regWriteD = mcOpD ? 1'b1 : 1'($urandom);
      mcDone = (fl.size() > 0) && ($urandom_range(0, 2) == 0);
      mcDoneAddr = mcDone ? RS'(fl[$urandom_range(0, fl.size() - 1)])
                          : RS'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 99) != 0);
      step();
    end
    rst_n = 1;
    clr();
    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

`default_nettype wire
